// File: rtl/cmd_scheduler_pkg.sv
// cmd_scheduler shared types: FSM encoding, command word layout, time helpers.
package cmd_scheduler_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t POP      = 3'd1;
  localparam state_t LATCH    = 3'd2;
  localparam state_t WAIT     = 3'd3;
  localparam state_t DISPATCH = 3'd4;

  localparam int CMD_W     = 80;
  localparam int ADDR_MSB  = 79;
  localparam int ADDR_LSB  = 72;
  localparam int OP_MSB    = 71;
  localparam int OP_LSB    = 64;
  localparam int START_MSB = 63;
  localparam int START_LSB = 32;
  localparam int DATA_MSB  = 31;
  localparam int DATA_LSB  = 0;

  // Wrap-safe: true when now is at or past start within half the range.
  function automatic logic time_reached(
    input logic [31:0] now,
    input logic [31:0] start
  );
    logic [31:0] d;
    d = now - start;
    return ~d[31];
  endfunction

endpackage

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at 255.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (inc && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Time-triggered command dispatcher between the EBI command FIFO and pin bus.
// Optional late-command drop enabled by defining CMD_SCHED_LATE_DROP_EN.
import cmd_scheduler_pkg::*;

module cmd_scheduler #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int LATE_WINDOW = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd_fifo_data_out,
  input  logic             cmd_fifo_empty,
  output logic             cmd_fifo_rd_en,
  input  logic [31:0]      global_clock,
  input  logic             flush,
  output logic [7:0]       bus_addr,
  output logic [7:0]       bus_cmd,
  output logic [31:0]      bus_data,
  output logic             bus_valid,
  input  logic             bus_ack,
  output logic             busy,
  output logic [7:0]       timeout_cnt,
  output logic [7:0]       late_cnt
);

`ifdef CMD_SCHED_LATE_DROP_EN
  localparam bit LATE_DROP = 1'b1;
`else
  localparam bit LATE_DROP = 1'b0;
`endif

  state_t state, state_nx;

  logic [CMD_W-1:0] cmd_q;
  logic [31:0]      cmd_start;
  logic [31:0]      tmo;
  logic             reached;
  logic             late;
  logic             drop;
  logic             expire;
  logic             tmo_inc;
  logic             enter_disp;

  assign cmd_start = cmd_q[START_MSB:START_LSB];
  assign reached   = time_reached(global_clock, cmd_start);
  assign late      = $signed(global_clock - cmd_start) > LATE_WINDOW;

  // LATCH is the cycle in which WAIT is entered, so the late check lives here.
  assign drop   = LATE_DROP && state == LATCH && late;
  assign expire = state == DISPATCH && tmo == 32'(ACK_TIMEOUT - 1);

  assign tmo_inc    = expire && !bus_ack && !flush;
  assign enter_disp = state_nx == DISPATCH && state != DISPATCH;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:     if (!cmd_fifo_empty) state_nx = POP;
        POP:      state_nx = LATCH;
        LATCH: begin
          if (drop)         state_nx = IDLE;
          else if (reached) state_nx = DISPATCH;
          else              state_nx = WAIT;
        end
        WAIT:     if (reached) state_nx = DISPATCH;
        DISPATCH: if (bus_ack || expire) state_nx = IDLE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = state != IDLE;
    cmd_fifo_rd_en = 1'b0;
    if (state == IDLE && !cmd_fifo_empty && !flush) begin
      cmd_fifo_rd_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
    end else if (state == POP) begin
      cmd_q <= cmd_fifo_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != DISPATCH) begin
      tmo <= '0;
    end else begin
      tmo <= tmo + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_cmd   <= '0;
      bus_data  <= '0;
    end else begin
      bus_valid <= state_nx == DISPATCH;
      if (enter_disp) begin
        bus_addr <= cmd_q[ADDR_MSB:ADDR_LSB];
        bus_cmd  <= cmd_q[OP_MSB:OP_LSB];
        bus_data <= cmd_q[DATA_MSB:DATA_LSB];
      end
    end
  end

  sat_counter8 u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (tmo_inc),
    .count (timeout_cnt)
  );

`ifdef CMD_SCHED_LATE_DROP_EN
  sat_counter8 u_late_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop),
    .count (late_cnt)
  );
`else
  assign late_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler with a small FIFO and time-base model.
`timescale 1ns/1ps
module tb_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] fifo_mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [79:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        rd_en;
  logic [31:0] gc = 32'd0;
  logic [31:0] gc_val = 32'd0;
  logic        gc_load = 1'b0;
  logic        flush = 1'b0;
  logic        bus_ack = 1'b0;
  logic [7:0]  bus_addr, bus_cmd, timeout_cnt, late_cnt;
  logic [31:0] bus_data;
  logic        bus_valid, busy;
  bit          rd_bad = 1'b0;
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      if (fifo_empty) begin
        rd_bad <= 1'b1;
      end else begin
        fifo_dout <= fifo_mem[rd_ptr[5:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
    gc <= gc_load ? gc_val : gc + 32'd1;
  end

  cmd_scheduler #(.ACK_TIMEOUT(16), .LATE_WINDOW(256)) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_fifo_data_out (fifo_dout),
    .cmd_fifo_empty    (fifo_empty),
    .cmd_fifo_rd_en    (rd_en),
    .global_clock      (gc),
    .flush             (flush),
    .bus_addr          (bus_addr),
    .bus_cmd           (bus_cmd),
    .bus_data          (bus_data),
    .bus_valid         (bus_valid),
    .bus_ack           (bus_ack),
    .busy              (busy),
    .timeout_cnt       (timeout_cnt),
    .late_cnt          (late_cnt)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] c,
                      input logic [31:0] st, input logic [31:0] d);
    fifo_mem[wr_ptr[5:0]] = {a, c, st, d};
    wr_ptr = wr_ptr + 1;
    #1;
  endtask

  task automatic load_gc(input logic [31:0] v);
    gc_val  = v;
    gc_load = 1'b1;
    tick();
    gc_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({rd_en, bus_valid, busy, bus_addr, bus_cmd, bus_data,
         timeout_cnt, late_cnt} !== 67'd0)
      $display("FAIL reset_in: got valid=%b busy=%b rd=%b", bus_valid, busy, rd_en);
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if ({rd_en, bus_valid, busy, bus_addr, bus_cmd, bus_data,
         timeout_cnt, late_cnt} !== 67'd0)
      $display("FAIL reset_idle: got valid=%b busy=%b rd=%b", bus_valid, busy, rd_en);
    else passed++;
  endtask

  task automatic test_wait_dispatch();
    int n = 0;
    load_gc(32'd50);
    push(8'h05, 8'h02, 32'd100, 32'hCAFEBABE);
    while (bus_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n >= 200 || gc !== 32'd101)
      $display("FAIL wait_rise: valid rose at gc=%0d want 101 (n=%0d)", gc, n);
    else passed++;
    total++;
    if ({bus_addr, bus_cmd, bus_data, busy} !== {8'h05, 8'h02, 32'hCAFEBABE, 1'b1})
      $display("FAIL wait_fields: got %h %h %h want 05 02 cafebabe", bus_addr, bus_cmd, bus_data);
    else passed++;
    tick();
    total++;
    if ({bus_valid, bus_addr, bus_data} !== {1'b1, 8'h05, 32'hCAFEBABE})
      $display("FAIL wait_hold: got valid=%b addr=%h want 1 05", bus_valid, bus_addr);
    else passed++;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    total++;
    if ({bus_valid, busy, rd_en, bus_addr} !== {3'b000, 8'h05})
      $display("FAIL wait_ack: got valid=%b busy=%b rd=%b addr=%h want 0 0 0 05",
               bus_valid, busy, rd_en, bus_addr);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int p[$];
    int v[$];
    logic [7:0] va[$];
    logic [31:0] vd[$];
    push(8'hA1, 8'h11, gc - 32'd5, 32'h1111_0001);
    push(8'hA2, 8'h22, gc - 32'd5, 32'h2222_0002);
    for (int c = 0; c < 24; c++) begin
      if (rd_en) p.push_back(c);
      if (bus_valid) begin
        v.push_back(c);
        va.push_back(bus_addr);
        vd.push_back(bus_data);
      end
      bus_ack = bus_valid;
      tick();
    end
    bus_ack = 1'b0;
    total++;
    if (!(p.size() == 2 && p[0] == 0 && p[1] == 4))
      $display("FAIL b2b_pops: got %0d pops first=%0d want 2 pops at 0,4",
               p.size(), (p.size() > 0) ? p[0] : -1);
    else passed++;
    total++;
    if (!(v.size() == 2 && v[0] == 3 && v[1] == 7))
      $display("FAIL b2b_valid: got %0d dispatches first=%0d want 2 at 3,7",
               v.size(), (v.size() > 0) ? v[0] : -1);
    else passed++;
    total++;
    if (!(va.size() == 2 && va[0] == 8'hA1 && va[1] == 8'hA2 &&
          vd[0] == 32'h1111_0001 && vd[1] == 32'h2222_0002))
      $display("FAIL b2b_order: got %0d dispatches, want A1 then A2", va.size());
    else passed++;
  endtask

  task automatic wait_and_ack(output int n, output logic [31:0] g);
    n = 0;
    while (bus_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    g = gc;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    int n;
    logic [31:0] g;
    load_gc(32'hFFFF_FFE0);
    push(8'h66, 8'h01, 32'hFFFF_FFF0, 32'h0000_0066);
    wait_and_ack(n, g);
    total++;
    if (n >= 100 || g !== 32'hFFFF_FFF1)
      $display("FAIL wrap_pre: valid rose at gc=%h want fffffff1", g);
    else passed++;
    load_gc(32'hFFFF_FFF8);
    push(8'h77, 8'h02, 32'h0000_0010, 32'h0000_0077);
    wait_and_ack(n, g);
    total++;
    if (n >= 100 || g !== 32'h0000_0011)
      $display("FAIL wrap_across: valid rose at gc=%h want 00000011", g);
    else passed++;
    total++;
    if ({bus_addr, bus_data, busy} !== {8'h77, 32'h77, 1'b0})
      $display("FAIL wrap_fields: got addr=%h busy=%b want 77 0", bus_addr, busy);
    else passed++;
  endtask

  task automatic test_flush();
    int n;
    logic [31:0] g;
    push(8'h88, 8'h03, gc + 32'd1000, 32'h0000_0088);
    for (int i = 0; i < 5; i++) tick();
    total++;
    if ({busy, bus_valid} !== 2'b10)
      $display("FAIL flush_wait_pre: got busy=%b valid=%b want 1 0", busy, bus_valid);
    else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if ({busy, bus_valid} !== 2'b00)
      $display("FAIL flush_wait: got busy=%b valid=%b want 0 0", busy, bus_valid);
    else passed++;
    push(8'h99, 8'h04, gc, 32'h0000_0099);
    for (int i = 0; i < 4; i++) tick();
    total++;
    if ({bus_valid, bus_addr} !== {1'b1, 8'h99})
      $display("FAIL flush_disp_pre: got valid=%b addr=%h want 1 99", bus_valid, bus_addr);
    else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if ({busy, bus_valid} !== 2'b00)
      $display("FAIL flush_disp: got busy=%b valid=%b want 0 0", busy, bus_valid);
    else passed++;
    flush = 1'b1;
    push(8'hAB, 8'h05, gc, 32'h0000_00AB);
    total++;
    if (rd_en !== 1'b0)
      $display("FAIL flush_idle_prio: got rd_en=%b want 0", rd_en);
    else passed++;
    tick();
    flush = 1'b0;
    wait_and_ack(n, g);
    total++;
    if (n >= 100 || bus_addr !== 8'hAB || busy !== 1'b0)
      $display("FAIL flush_idle_keep: got addr=%h busy=%b want ab 0", bus_addr, busy);
    else passed++;
  endtask

  task automatic test_late();
    int hi = 0;
    load_gc(32'd1000);
    push(8'hC1, 8'h06, 32'd500, 32'h0000_00C1);
`ifdef CMD_SCHED_LATE_DROP_EN
    for (int c = 0; c < 10; c++) begin
      if (bus_valid) hi++;
      tick();
    end
    total++;
    if (hi != 0 || late_cnt !== 8'd1 || busy !== 1'b0)
      $display("FAIL late_drop: got valid_cycles=%0d late_cnt=%0d want 0 1", hi, late_cnt);
    else passed++;
`else
    for (int c = 0; c < 3; c++) tick();
    total++;
    if ({bus_valid, bus_addr} !== {1'b1, 8'hC1} || late_cnt !== 8'd0)
      $display("FAIL late_pass: got valid=%b addr=%h late_cnt=%0d want 1 c1 0",
               bus_valid, bus_addr, late_cnt);
    else passed++;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
`endif
  endtask

  task automatic test_timeout();
    int hi = 0;
    push(8'h33, 8'h44, gc, 32'h0BAD_F00D);
    for (int c = 0; c < 24; c++) begin
      if (bus_valid) hi++;
      tick();
    end
    total++;
    if (hi != 16 || timeout_cnt !== 8'd1 || busy !== 1'b0)
      $display("FAIL tmo_first: got valid_cycles=%0d timeout_cnt=%0d want 16 1",
               hi, timeout_cnt);
    else passed++;
    push(8'h34, 8'h44, gc, 32'h0);
    for (int c = 0; c < 3; c++) tick();
    for (int c = 0; c < 15; c++) tick();
    bus_ack = 1'b1;
    total++;
    if (bus_valid !== 1'b1)
      $display("FAIL tmo_ack_edge_valid: got valid=%b want 1", bus_valid);
    else passed++;
    tick();
    bus_ack = 1'b0;
    total++;
    if (timeout_cnt !== 8'd1 || busy !== 1'b0)
      $display("FAIL tmo_ack_edge: got timeout_cnt=%0d busy=%b want 1 0", timeout_cnt, busy);
    else passed++;
    for (int r = 1; r < 300; r++) begin
      push(8'h35, 8'h44, gc, 32'h0);
      for (int c = 0; c < 22; c++) tick();
      if (r == 254) begin
        total++;
        if (timeout_cnt !== 8'd255)
          $display("FAIL tmo_reach255: got %0d want 255", timeout_cnt);
        else passed++;
      end
    end
    total++;
    if (timeout_cnt !== 8'd255 || busy !== 1'b0)
      $display("FAIL tmo_saturate: got %0d busy=%b want 255 0", timeout_cnt, busy);
    else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wait_dispatch();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_late();
    test_timeout();
    total++;
    if (rd_bad !== 1'b0)
      $display("FAIL rd_on_empty: got %b want 0", rd_bad);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
